// File: rtl/aes_dec_round_ctrl_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helpers for the AES-128 decrypt sequencer.
package aes_dec_round_ctrl_pkg;

  localparam int unsigned AesNr   = 10;
  localparam int unsigned AesBlkW = 128;
  localparam int unsigned AesRkAw = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRound = 2'd1,
    StDone  = 2'd2
  } ctrl_state_e;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] res;
    sq  = a;
    res = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      res = gf_mul(res, sq);
    end
    return res;
  endfunction

  // Inverse S-box: undo the affine map, then invert in the field
  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] x;
    x = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    return gf_inv(x);
  endfunction

  // Byte i of a block, byte 0 in the top bits; column-major state (i = 4*col + row)
  function automatic logic [7:0] get_byte(input logic [AesBlkW-1:0] blk, input int i);
    return blk[AesBlkW-1-8*i -: 8];
  endfunction

  function automatic logic [AesBlkW-1:0] inv_shift_rows(input logic [AesBlkW-1:0] blk);
    logic [AesBlkW-1:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[AesBlkW-1-8*(4*c+r) -: 8] = get_byte(blk, 4*((c - r + 4) % 4) + r);
      end
    end
    return res;
  endfunction

  function automatic logic [AesBlkW-1:0] inv_sub_bytes(input logic [AesBlkW-1:0] blk);
    logic [AesBlkW-1:0] res;
    res = '0;
    for (int i = 0; i < 16; i++) begin
      res[AesBlkW-1-8*i -: 8] = inv_sbox(get_byte(blk, i));
    end
    return res;
  endfunction

  function automatic logic [AesBlkW-1:0] inv_mix_columns(input logic [AesBlkW-1:0] blk);
    logic [AesBlkW-1:0] res;
    logic [7:0] a0, a1, a2, a3;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = get_byte(blk, 4*c);
      a1 = get_byte(blk, 4*c+1);
      a2 = get_byte(blk, 4*c+2);
      a3 = get_byte(blk, 4*c+3);
      res[AesBlkW-1-8*(4*c) -: 8]   = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^
                                      gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      res[AesBlkW-1-8*(4*c+1) -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^
                                      gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      res[AesBlkW-1-8*(4*c+2) -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^
                                      gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      res[AesBlkW-1-8*(4*c+3) -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^
                                      gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_dec_round_ctrl_inv_round.sv
// One combinational AES inverse round; InvMixColumns is skipped on the last round.
module aes_dec_round_ctrl_inv_round
  import aes_dec_round_ctrl_pkg::*;
(
  input  logic [AesBlkW-1:0] state_in,
  input  logic [AesBlkW-1:0] rk,
  input  logic               last,
  output logic [AesBlkW-1:0] state_out
);

  logic [AesBlkW-1:0] shifted;
  logic [AesBlkW-1:0] subbed;
  logic [AesBlkW-1:0] keyed;

  // InvShiftRows -> InvSubBytes -> AddRoundKey -> (InvMixColumns unless last)
  always_comb begin
    shifted   = inv_shift_rows(state_in);
    subbed    = inv_sub_bytes(shifted);
    keyed     = subbed ^ rk;
    state_out = last ? keyed : inv_mix_columns(keyed);
  end

endmodule

// File: rtl/aes_dec_round_ctrl.sv
// Iterative AES-128 decryption sequencer: one inverse round per clock.
module aes_dec_round_ctrl
  import aes_dec_round_ctrl_pkg::*;
#(
  parameter int unsigned Nr   = AesNr,
  parameter int unsigned RkAw = AesRkAw
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               key_valid,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [AesBlkW-1:0] in_data,
  output logic [RkAw-1:0]    rk_idx,
  input  logic [AesBlkW-1:0] rk_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [AesBlkW-1:0] out_data,
  output logic               busy,
  output logic               abort
);

  ctrl_state_e        st_q, st_d;
  logic [RkAw-1:0]    round_q, round_d;
  logic [AesBlkW-1:0] blk_q, blk_d;
  logic               abort_q, abort_d;
  logic               accept;
  logic               last;
  logic [AesBlkW-1:0] round_out;

  aes_dec_round_ctrl_inv_round u_inv_round (
    .state_in  (blk_q),
    .rk        (rk_data),
    .last      (last),
    .state_out (round_out)
  );

  // Handshake and key-index decode; IDLE/DONE pre-address the first key of the next block
  always_comb begin
    in_ready = key_valid & ((st_q == StIdle) | ((st_q == StDone) & out_ready));
    accept   = in_valid & in_ready;
    rk_idx   = (st_q == StRound) ? round_q : RkAw'(Nr);
    last     = (round_q == '0);
  end

  // Next-state: FSM, round counter, datapath register and abort pulse
  always_comb begin
    st_d    = st_q;
    round_d = round_q;
    blk_d   = blk_q;
    abort_d = 1'b0;
    case (st_q)
      StIdle: begin
        if (accept) begin
          st_d    = StRound;
          blk_d   = in_data ^ rk_data;
          round_d = RkAw'(Nr - 1);
        end
      end
      StRound: begin
        if (!key_valid) begin
          // Key store went stale: drop the block rather than finish with bad keys
          st_d    = StIdle;
          abort_d = 1'b1;
        end else begin
          blk_d = round_out;
          if (last) begin
            st_d = StDone;
          end else begin
            round_d = round_q - 1'b1;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          if (accept) begin
            st_d    = StRound;
            blk_d   = in_data ^ rk_data;
            round_d = RkAw'(Nr - 1);
          end else begin
            st_d = StIdle;
          end
        end
      end
      default: st_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st_q    <= StIdle;
      round_q <= '0;
      blk_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      round_q <= round_d;
      blk_q   <= blk_d;
      abort_q <= abort_d;
    end
  end

  // Registered outputs straight from state
  always_comb begin
    out_valid = (st_q == StDone);
    out_data  = blk_q;
    busy      = (st_q == StRound);
    abort     = abort_q;
  end

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Directed bench for aes_dec_round_ctrl using FIPS-197 vectors and a bench-side key schedule.
module tb_aes_dec_round_ctrl;

  logic         clk;
  logic         reset_n;
  logic         key_valid;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic         abort;

  logic [127:0] rk_mem [0:15];

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] KeyB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CtB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PtB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KeyC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CtC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PtC  = 128'h00112233445566778899aabbccddeeff;

  aes_dec_round_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_valid (key_valid),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .abort     (abort)
  );

  // Asynchronous-read key store
  assign rk_data = rk_mem[rk_idx];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    while (bb != 8'h00) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // Forward S-box by brute-force inverse search plus affine map
  function automatic logic [7:0] m_sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] s;
    inv = 8'h00;
    for (int j = 1; j < 256; j++) begin
      if (m_mul(a, 8'(j)) == 8'h01) inv = 8'(j);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
        {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {m_sbox(t[31:24]) ^ rcon, m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0])};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      rk_mem[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    end
  endtask

  // Offer a block in IDLE and step past the accepting edge
  task automatic start_block(input logic [127:0] ct);
    in_valid = 1'b1;
    in_data  = ct;
    #1;
    check_eq("accept_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called one cycle after accept; waits (bounded) for out_valid and checks result
  task automatic wait_result(input logic [127:0] pt, input bit chk_rk, input bit garble);
    int lat;
    lat = 1;
    while (!out_valid && lat < 30) begin
      if (chk_rk && lat <= 10) check_eq("rk_seq", rk_idx, 128'(10 - lat));
      if (garble) begin
        in_valid = lat[0];
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        #1;
        check_eq("round_in_ready", in_ready, 1'b0);
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check_eq("latency", 128'(lat), 128'd11);
    check_eq("plaintext", out_data, pt);
    check_eq("done_busy", busy, 1'b0);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("drain_valid", out_valid, 1'b0);
  endtask

  initial begin
    reset_n   = 1'b0;
    key_valid = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    load_key(KeyB);
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_abort", abort, 1'b0);
    check_eq("rst_out_data", out_data, 128'h0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_rk_idx", rk_idx, 128'd10);
    check_eq("rst_in_ready", in_ready, 1'b0);
    reset_n   = 1'b1;
    key_valid = 1'b1;
    @(negedge clk);

    // App.B vector
    start_block(CtB);
    wait_result(PtB, 1'b0, 1'b0);
    drain();

    // App.C.1 vector with round-key index sequence
    load_key(KeyC);
    start_block(CtC);
    wait_result(PtC, 1'b1, 1'b0);
    drain();

    // Backpressure, then back-to-back accept from DONE
    load_key(KeyB);
    start_block(CtB);
    wait_result(PtB, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = CtC;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("stall_in_ready", in_ready, 1'b0);
      check_eq("stall_data", out_data, PtB);
      check_eq("stall_valid", out_valid, 1'b1);
      @(negedge clk);
    end
    load_key(KeyC);
    out_ready = 1'b1;
    #1;
    check_eq("b2b_in_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_eq("b2b_busy", busy, 1'b1);
    check_eq("b2b_valid", out_valid, 1'b0);
    wait_result(PtC, 1'b0, 1'b0);
    drain();

    // key_valid falls at round 5
    load_key(KeyB);
    start_block(CtB);
    repeat (4) @(negedge clk);
    check_eq("abort_rk_idx", rk_idx, 128'd5);
    key_valid = 1'b0;
    @(negedge clk);
    check_eq("abort_pulse", abort, 1'b1);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_valid", out_valid, 1'b0);
    in_valid = 1'b1;
    in_data  = CtB;
    #1;
    check_eq("nokey_in_ready", in_ready, 1'b0);
    @(negedge clk);
    check_eq("abort_clear", abort, 1'b0);
    check_eq("nokey_busy", busy, 1'b0);
    check_eq("nokey_valid", out_valid, 1'b0);
    in_valid  = 1'b0;
    key_valid = 1'b1;
    #1;
    check_eq("key_back_ready", in_ready, 1'b1);
    @(negedge clk);

    // Reset at round 3, then a fresh block
    start_block(CtB);
    repeat (6) @(negedge clk);
    check_eq("mid_rk_idx", rk_idx, 128'd3);
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_valid", out_valid, 1'b0);
    check_eq("mid_rst_data", out_data, 128'h0);
    check_eq("mid_rst_rk_idx", rk_idx, 128'd10);
    reset_n = 1'b1;
    @(negedge clk);
    start_block(CtB);
    wait_result(PtB, 1'b0, 1'b0);
    drain();

    // Garbage offered during rounds must be ignored
    start_block(CtB);
    wait_result(PtB, 1'b0, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
